// File: rtl/enc_pkg.sv
// Shared LEGv8-subset encoding constants, op enum and loader FSM states.
// Used by instr_encode_comb and instr_encoder_loader (optional ENC_RANGE_CHECK_EN).
package enc_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_ADDS = 4'd1,
        OP_SUBS = 4'd2,
        OP_AND  = 4'd3,
        OP_EOR  = 4'd4,
        OP_LSR  = 4'd5,
        OP_LDUR = 4'd6,
        OP_STUR = 4'd7,
        OP_B    = 4'd8,
        OP_BLT  = 4'd9,
        OP_CBZ  = 4'd10
    } op_t;

    localparam logic [9:0]  OP10_ADDI = 10'b1001000100;
    localparam logic [10:0] OP11_ADDS = 11'b10101011000;
    localparam logic [10:0] OP11_SUBS = 11'b11101011000;
    localparam logic [10:0] OP11_AND  = 11'b10001010000;
    localparam logic [10:0] OP11_EOR  = 11'b11001010000;
    localparam logic [10:0] OP11_LSR  = 11'b11010011010;
    localparam logic [10:0] OP11_LDUR = 11'b11111000010;
    localparam logic [10:0] OP11_STUR = 11'b11111000000;
    localparam logic [7:0]  OP8_BLT   = 8'b01010100;
    localparam logic [7:0]  OP8_CBZ   = 8'b10110100;
    localparam logic [5:0]  OP6_B     = 6'b000101;
    localparam logic [4:0]  COND_LT   = 5'b01011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when v, read as two's complement, fits in a w-bit signed field.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
        logic signed [31:0] top;
        top = $signed(v) >>> (w - 1);
        return (top == 0) || (top == -1);
    endfunction

    function automatic logic fits_unsigned(input logic [31:0] v, input int unsigned w);
        return (v >> w) == 32'd0;
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational field -> 32-bit LEGv8 word encoder with illegal-op and
// immediate-range flags (range flag consumed only under ENC_RANGE_CHECK_EN).
module instr_encode_comb
    import enc_pkg::*;
(
    input  logic [3:0]  op_code,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_err
);

    op_t op;
    assign op = op_t'(op_code);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        word      = 32'd0;
        illegal   = 1'b0;
        range_err = 1'b0;
        case (op)
            OP_ADDI: begin
                word      = {OP10_ADDI, imm[11:0], rn, rd};
                range_err = !fits_unsigned(imm, 12);
            end
            OP_ADDS: word = {OP11_ADDS, rm, 6'd0, rn, rd};
            OP_SUBS: word = {OP11_SUBS, rm, 6'd0, rn, rd};
            OP_AND:  word = {OP11_AND,  rm, 6'd0, rn, rd};
            OP_EOR:  word = {OP11_EOR,  rm, 6'd0, rn, rd};
            OP_LSR: begin
                word      = {OP11_LSR, 5'd0, imm[5:0], rn, rd};
                range_err = !fits_unsigned(imm, 6);
            end
            OP_LDUR: begin
                word      = {OP11_LDUR, imm[8:0], 2'b00, rn, rd};
                range_err = !fits_signed(imm, 9);
            end
            OP_STUR: begin
                word      = {OP11_STUR, imm[8:0], 2'b00, rn, rd};
                range_err = !fits_signed(imm, 9);
            end
            OP_B: begin
                word      = {OP6_B, imm[25:0]};
                range_err = !fits_signed(imm, 26);
            end
            OP_BLT: begin
                word      = {OP8_BLT, imm[18:0], COND_LT};
                range_err = !fits_signed(imm, 19);
            end
            OP_CBZ: begin
                word      = {OP8_CBZ, imm[18:0], rd};
                range_err = !fits_signed(imm, 19);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Session loader: encodes accepted requests and streams them into imem, one word
// per cycle. ENC_RANGE_CHECK_EN adds immediate range rejection and err_range.
module instr_encoder_loader
    import enc_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic              op_last,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic [ADDR_W:0]   count,
`ifdef ENC_RANGE_CHECK_EN
    output logic              err_range,
`endif
    output logic              err_illegal,
    output logic              err_full
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    logic [1:0]        state_q,       state_d;
    logic [ADDR_W-1:0] ptr_q,         ptr_d;
    logic [ADDR_W:0]   count_q,       count_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_full_q,    err_full_d;
    logic              we_q,          we_d;
    logic [ADDR_W-1:0] addr_q,        addr_d;
    logic [31:0]       wdata_q,       wdata_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        enc_range_err;
    logic        reject;

    instr_encode_comb u_encode (
        .op_code   (op_code),
        .rd        (rd),
        .rn        (rn),
        .rm        (rm),
        .imm       (imm),
        .word      (enc_word),
        .illegal   (enc_illegal),
        .range_err (enc_range_err)
    );

`ifdef ENC_RANGE_CHECK_EN
    logic err_range_q, err_range_d;
    assign reject = enc_illegal | enc_range_err;
`else
    // Without range checking, out-of-range immediates are simply truncated.
    logic unused_range_err;
    assign unused_range_err = enc_range_err;
    assign reject           = enc_illegal;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        err_illegal_d = err_illegal_q;
        err_full_d    = err_full_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
`ifdef ENC_RANGE_CHECK_EN
        err_range_d   = err_range_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    ptr_d         = base_addr;
                    count_d       = '0;
                    err_illegal_d = 1'b0;
                    err_full_d    = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
                    err_range_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (op_valid) begin
                    if (reject) begin
                        if (enc_illegal) err_illegal_d = 1'b1;
`ifdef ENC_RANGE_CHECK_EN
                        else             err_range_d   = 1'b1;
`endif
                        if (op_last) state_d = ST_DONE;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + PTR_ONE;
                        count_d = count_q + CNT_ONE;
                        if (op_last) begin
                            state_d = ST_DONE;
                        end else if (ptr_q == LAST_ADDR) begin
                            state_d    = ST_DONE;
                            err_full_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            count_q       <= '0;
            err_illegal_q <= 1'b0;
            err_full_q    <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
`ifdef ENC_RANGE_CHECK_EN
            err_range_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            err_illegal_q <= err_illegal_d;
            err_full_q    <= err_full_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
`ifdef ENC_RANGE_CHECK_EN
            err_range_q   <= err_range_d;
`endif
        end
    end

    assign op_ready    = (state_q == ST_LOAD);
    assign done        = (state_q == ST_DONE);
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign err_illegal = err_illegal_q;
    assign err_full    = err_full_q;
`ifdef ENC_RANGE_CHECK_EN
    assign err_range   = err_range_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed cases plus randomized
// sessions against an arithmetic encoding/session model.
module tb_instr_encoder_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_code;
    logic              op_last;
    logic [4:0]        rd, rn, rm;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err_illegal;
    logic              err_full;
`ifdef ENC_RANGE_CHECK_EN
    logic              err_range;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_last     (op_last),
        .rd          (rd),
        .rn          (rn),
        .rm          (rm),
        .imm         (imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .done        (done),
        .count       (count),
`ifdef ENC_RANGE_CHECK_EN
        .err_range   (err_range),
`endif
        .err_illegal (err_illegal),
        .err_full    (err_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request list for one session.
    int s_op[16], s_rd[16], s_rn[16], s_rm[16], s_imm[16];
    bit s_last[16];
    int s_n;

    int          obs_addr[$];
    logic [31:0] obs_data[$];

    // Session model: state after the most recent edge plus this cycle's write.
    bit          m_load, m_ill, m_full, m_rng;
    int          m_ptr, m_count;
    bit          e_we, e_done;
    int          e_addr;
    logic [31:0] e_data;

    function automatic logic [31:0] ref_encode(input int op, input int d, input int n,
                                               input int m, input int im);
        longint w;
        longint i64;
        i64 = im;
        case (op)
            0:  w = (64'h244 << 22) + ((i64 & 64'hFFF) << 10) + (n << 5) + d;
            1:  w = (64'h558 << 21) + (m << 16) + (n << 5) + d;
            2:  w = (64'h758 << 21) + (m << 16) + (n << 5) + d;
            3:  w = (64'h450 << 21) + (m << 16) + (n << 5) + d;
            4:  w = (64'h650 << 21) + (m << 16) + (n << 5) + d;
            5:  w = (64'h69A << 21) + ((i64 & 64'h3F) << 10) + (n << 5) + d;
            6:  w = (64'h7C2 << 21) + ((i64 & 64'h1FF) << 12) + (n << 5) + d;
            7:  w = (64'h7C0 << 21) + ((i64 & 64'h1FF) << 12) + (n << 5) + d;
            8:  w = (64'h5 << 26) + (i64 & 64'h3FFFFFF);
            9:  w = (64'h54 << 24) + ((i64 & 64'h7FFFF) << 5) + 11;
            10: w = (64'hB4 << 24) + ((i64 & 64'h7FFFF) << 5) + d;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic bit ref_in_range(input int op, input int im);
        case (op)
            0:       return im >= 0 && im <= 4095;
            5:       return im >= 0 && im <= 63;
            6, 7:    return im >= -256 && im <= 255;
            8:       return im >= -(1 << 25) && im < (1 << 25);
            9, 10:   return im >= -(1 << 18) && im < (1 << 18);
            default: return 1'b1;
        endcase
    endfunction

    function automatic int rand_imm(input int op);
        case (op)
            0:       return int'($urandom % 4096);
            5:       return int'($urandom % 64);
            6, 7:    return int'($urandom % 512) - 256;
            8:       return int'($urandom % (1 << 26)) - (1 << 25);
            9, 10:   return int'($urandom % (1 << 19)) - (1 << 18);
            default: return int'($urandom);
        endcase
    endfunction

    function automatic void model_reset();
        m_load = 0; m_ill = 0; m_full = 0; m_rng = 0;
        m_ptr = 0; m_count = 0; e_we = 0; e_done = 0;
    endfunction

    task automatic set_op(input int i, input int op, input int d, input int n,
                          input int m, input int im, input bit last);
        s_op[i] = op; s_rd[i] = d; s_rn[i] = n; s_rm[i] = m; s_imm[i] = im; s_last[i] = last;
    endtask

    task automatic drive_op(input int i);
        op_code = 4'(s_op[i]); rd = 5'(s_rd[i]); rn = 5'(s_rn[i]);
        rm = 5'(s_rm[i]); imm = s_imm[i]; op_last = s_last[i];
    endtask

    task automatic model_accept(input int i);
        bit ill, rng, wrote, hit;
        ill = s_op[i] > 10;
`ifdef ENC_RANGE_CHECK_EN
        rng = !ill && !ref_in_range(s_op[i], s_imm[i]);
`else
        rng = 0;
`endif
        wrote = 0; hit = 0;
        if (ill) m_ill = 1;
        else if (rng) m_rng = 1;
        else begin
            wrote = 1;
            e_we = 1; e_addr = m_ptr;
            e_data = ref_encode(s_op[i], s_rd[i], s_rn[i], s_rm[i], s_imm[i]);
            hit = (m_ptr == DEPTH - 1);
            m_ptr = (m_ptr + 1) % (1 << ADDR_W);
            m_count++;
        end
        if (s_last[i] || (wrote && hit)) begin
            if (!s_last[i]) m_full = 1;
            m_load = 0;
            e_done = 1;
        end
    endtask

    // Starts a session at base and feeds s_op[0..s_n-1], checking every cycle.
    task automatic run_session(input int base, input int gap_pct);
        int  idx, cyc;
        bit  finished;
        obs_addr.delete();
        obs_data.delete();
        @(negedge clk);
        start = 1; base_addr = ADDR_W'(base); op_valid = 0;
        @(negedge clk);
        start = 0;
        m_load = 1; m_ptr = base; m_count = 0; m_ill = 0; m_full = 0; m_rng = 0;
        e_we = 0; e_done = 0;
        idx = 0; cyc = 0; finished = 0;
        while (cyc < 200) begin
            n_checks++;
            if (op_ready !== m_load) begin
                n_fail++; $display("FAIL op_ready cyc %0d: got %b want %b", cyc, op_ready, m_load);
            end
            n_checks++;
            if (imem_we !== e_we) begin
                n_fail++; $display("FAIL imem_we cyc %0d: got %b want %b", cyc, imem_we, e_we);
            end
            if (e_we) begin
                n_checks++;
                if (imem_addr !== ADDR_W'(e_addr) || imem_wdata !== e_data) begin
                    n_fail++;
                    $display("FAIL write cyc %0d: got %0d/%h want %0d/%h",
                             cyc, imem_addr, imem_wdata, e_addr, e_data);
                end
            end
            n_checks++;
            if (done !== e_done) begin
                n_fail++; $display("FAIL done cyc %0d: got %b want %b", cyc, done, e_done);
            end
            n_checks++;
            if (count !== (ADDR_W + 1)'(m_count) || err_illegal !== m_ill || err_full !== m_full) begin
                n_fail++;
                $display("FAIL status cyc %0d: got cnt=%0d ill=%b full=%b want cnt=%0d ill=%b full=%b",
                         cyc, count, err_illegal, err_full, m_count, m_ill, m_full);
            end
`ifdef ENC_RANGE_CHECK_EN
            n_checks++;
            if (err_range !== m_rng) begin
                n_fail++; $display("FAIL err_range cyc %0d: got %b want %b", cyc, err_range, m_rng);
            end
`endif
            if (imem_we === 1'b1) begin
                obs_addr.push_back(int'(imem_addr));
                obs_data.push_back(imem_wdata);
            end
            if (e_done) begin
                finished = 1;
                break;
            end
            e_we = 0; e_done = 0;
            // Stray start pulses while loading must be ignored.
            start = ($urandom % 8 == 0);
            base_addr = ADDR_W'($urandom);
            op_valid = (idx < s_n) && (int'($urandom % 100) >= gap_pct);
            if (idx < s_n) drive_op(idx);
            if (op_valid && m_load) begin
                model_accept(idx);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0;
        n_checks++;
        if (!finished) begin
            n_fail++; $display("FAIL session_timeout: got no done within 200 cycles, want done");
        end
        op_valid = 0;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b0 || done !== 1'b0 || imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: got ready=%b done=%b we=%b want 0 0 0", op_ready, done, imem_we);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (op_ready !== 0 || imem_we !== 0 || imem_addr !== 0 || imem_wdata !== 0 || done !== 0 ||
            count !== 0 || err_illegal !== 0 || err_full !== 0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b we=%b addr=%0d wdata=%h done=%b cnt=%0d ill=%b full=%b want all 0",
                     op_ready, imem_we, imem_addr, imem_wdata, done, count, err_illegal, err_full);
        end
    endtask

    task automatic test_single_addi();
        s_n = 1;
        set_op(0, 0, 1, 31, 0, 5, 1);
        run_session(0, 0);
        n_checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'h910017E1 || obs_addr[0] != 0) begin
            n_fail++;
            $display("FAIL addi_single: got n=%0d %h@%0d want 1 910017e1@0",
                     obs_data.size(), obs_data[0], obs_addr[0]);
        end
        n_checks++;
        if (count !== 1) begin
            n_fail++; $display("FAIL addi_count: got %0d want 1", count);
        end
    endtask

    task automatic test_back_to_back();
        s_n = 3;
        set_op(0, 8, 0, 0, 0, -1, 0);
        set_op(1, 9, 0, 0, 0, 2, 0);
        set_op(2, 10, 3, 0, 0, -2, 1);
        run_session(8, 0);
        n_checks++;
        if (obs_data.size() != 3 || obs_addr[0] != 8 || obs_addr[1] != 9 || obs_addr[2] != 10 ||
            obs_data[0] !== 32'h17FFFFFF || obs_data[1] !== 32'h5400004B || obs_data[2] !== 32'hB4FFFFC3) begin
            n_fail++;
            $display("FAIL branch_b2b: got n=%0d %h %h %h want 3 17ffffff 5400004b b4ffffc3 at 8..10",
                     obs_data.size(), obs_data[0], obs_data[1], obs_data[2]);
        end
    endtask

    task automatic test_illegal_mid();
        s_n = 3;
        set_op(0, 7, 2, 4, 0, -8, 0);
        set_op(1, 12, 1, 1, 1, 0, 0);
        set_op(2, 1, 5, 6, 7, 0, 1);
        run_session(40, 0);
        n_checks++;
        if (obs_data.size() != 2 || obs_data[0] !== 32'hF81F8082 || obs_addr[0] != 40 || obs_addr[1] != 41) begin
            n_fail++;
            $display("FAIL stur_illegal: got n=%0d %h@%0d next@%0d want 2 f81f8082@40 next@41",
                     obs_data.size(), obs_data[0], obs_addr[0], obs_addr[1]);
        end
        n_checks++;
        if (err_illegal !== 1'b1 || count !== 2) begin
            n_fail++; $display("FAIL illegal_flags: got ill=%b cnt=%0d want 1 2", err_illegal, count);
        end
    endtask

    task automatic test_full();
        s_n = 3;
        for (int i = 0; i < 3; i++) set_op(i, 1, i, i + 1, i + 2, 0, 0);
        run_session(DEPTH - 2, 0);
        n_checks++;
        if (obs_data.size() != 2 || err_full !== 1'b1 || count !== 2) begin
            n_fail++;
            $display("FAIL full: got writes=%0d full=%b cnt=%0d want 2 1 2", obs_data.size(), err_full, count);
        end
    endtask

    task automatic test_imm_range();
        s_n = 1;
        set_op(0, 0, 1, 31, 0, 4096, 1);
        run_session(100, 0);
`ifdef ENC_RANGE_CHECK_EN
        n_checks++;
        if (obs_data.size() != 0 || err_range !== 1'b1) begin
            n_fail++; $display("FAIL addi_range: got writes=%0d rng=%b want 0 1", obs_data.size(), err_range);
        end
`else
        n_checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'h910003E1) begin
            n_fail++; $display("FAIL addi_trunc: got n=%0d %h want 1 910003e1", obs_data.size(), obs_data[0]);
        end
`endif
    endtask

    task automatic test_random();
        for (int s = 0; s < 24; s++) begin
            int base, op;
            s_n = 1 + int'($urandom % 10);
            base = ($urandom % 4 == 0) ? DEPTH - 1 - int'($urandom % 4) : int'($urandom % DEPTH);
            for (int i = 0; i < s_n; i++) begin
                op = ($urandom % 10 == 0) ? 11 + int'($urandom % 5) : int'($urandom % 11);
                set_op(i, op, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
                       ($urandom % 2 == 1) ? rand_imm(op) : int'($urandom), i == s_n - 1);
            end
            run_session(base, 30);
        end
    endtask

    task automatic test_reset_mid();
        s_n = 8;
        for (int i = 0; i < 8; i++) set_op(i, 2, i, i + 3, i + 5, 0, i == 7);
        @(negedge clk);
        start = 1; base_addr = 5;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 3; i++) begin
            op_valid = 1; drive_op(i);
            @(negedge clk);
        end
        drive_op(3);
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (op_ready !== 0 || imem_we !== 0 || imem_addr !== 0 || imem_wdata !== 0 || done !== 0 ||
            count !== 0 || err_illegal !== 0 || err_full !== 0) begin
            n_fail++;
            $display("FAIL async_reset: got ready=%b we=%b addr=%0d wdata=%h done=%b cnt=%0d want all 0",
                     op_ready, imem_we, imem_addr, imem_wdata, done, count);
        end
        @(negedge clk);
        n_checks++;
        if (imem_we !== 0 || done !== 0) begin
            n_fail++; $display("FAIL reset_hold: got we=%b done=%b want 0 0", imem_we, done);
        end
        op_valid = 0;
        rst_n = 1;
        model_reset();
        s_n = 1;
        set_op(0, 0, 1, 31, 0, 5, 1);
        run_session(3, 0);
        n_checks++;
        if (obs_data.size() != 1 || obs_addr[0] != 3 || obs_data[0] !== 32'h910017E1) begin
            n_fail++;
            $display("FAIL restart: got n=%0d %h@%0d want 1 910017e1@3", obs_data.size(), obs_data[0], obs_addr[0]);
        end
    endtask

    initial begin
        rst_n = 0; start = 0; base_addr = '0; op_valid = 0; op_code = '0; op_last = 0;
        rd = '0; rn = '0; rm = '0; imm = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1;
        test_single_addi();
        test_back_to_back();
        test_illegal_mid();
        test_full();
        test_imm_range();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
